// File: rtl/camera_cfg_pkg.sv
// camera_cfg_pkg: shared table markers, sequencer state type and ms-to-cycle helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package camera_cfg_pkg;

   // Table entry that terminates the init sequence.
   localparam logic [15:0] CFG_END   = 16'hFFFF;
   // Table entry that inserts a fixed millisecond pause instead of a write.
   localparam logic [15:0] CFG_DELAY = 16'hFFF0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_WAIT_IDLE,
      ST_WAIT_ACCEPT,
      ST_WAIT_DONE,
      ST_DELAY,
      ST_ADVANCE,
      ST_FINISH
   } cfg_state_t;

   // Number of clk cycles in 'ms' milliseconds at 'clk_freq' Hz.
   function automatic int ms_to_cycles(input int ms, input int clk_freq);
      return ms * (clk_freq / 1000);
   endfunction

endpackage

// File: rtl/camera_config_rom.sv
// camera_config_rom: camera register-init table, {reg_addr, reg_data} per entry, closed by CFG_END.
// Latency: 1 cycle from addr to data.
// Backpressure: none; a new address may be presented every cycle.
module camera_config_rom
   import camera_cfg_pkg::*;
#(
   parameter int ROM_AW = 8
)(
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [15:0]       data
);

   logic [15:0] entry;

   // Table contents: soft reset, settle pause, then output format and clocking.
   always_comb begin
      entry = CFG_END;
      case (int'(addr))
         0:       entry = 16'h1280;   // COM7: register soft reset
         1:       entry = CFG_DELAY;  // let the sensor come out of reset
         2:       entry = 16'h1204;   // COM7: RGB output
         3:       entry = 16'h1101;   // CLKRC: prescale input clock by 2
         4:       entry = 16'h0C00;   // COM3: scaling off
         5:       entry = 16'h3E00;   // COM14: PCLK divider off
         6:       entry = 16'h40D0;   // COM15: full-range RGB565
         7:       entry = 16'h3A04;   // TSLB: output sequence
         default: entry = CFG_END;
      endcase
   end

   // Registered read port gives the one-cycle table latency.
   always_ff @(posedge clk) begin
      data <= entry;
   end

endmodule

// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: walks the register-init table, one SCCB write per entry, with delay/end markers.
// Latency: 4 cycles from config_start to the first sccb_start when entry 0 is a write and sccb_ready is high.
// Backpressure: every start waits for sccb_ready, one transaction outstanding; CFG_AUTOSTART_EN adds power-up auto-start.
module camera_config_sequencer
   import camera_cfg_pkg::*;
#(
   parameter int CLK_FREQ       = 25000000,
   parameter int ROM_AW         = 8,
   parameter int DELAY_MS       = 10,
   parameter int ACCEPT_TIMEOUT = 64,
   parameter int POWERUP_MS     = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              config_start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   input  logic              sccb_ready,
   output logic              sccb_start,
   output logic [7:0]        sccb_address,
   output logic [7:0]        sccb_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ROM_AW:0]   write_count
);

   localparam int DELAY_CYCLES = ms_to_cycles(DELAY_MS, CLK_FREQ);
   localparam int DCW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int TCW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
   localparam logic [ROM_AW:0] WC_MAX = {1'b1, {ROM_AW{1'b0}}};

   cfg_state_t        state, state_nxt;
   logic [ROM_AW-1:0] rom_addr_nxt;
   logic              sccb_start_nxt;
   logic [7:0]        sccb_address_nxt, sccb_data_nxt;
   logic              busy_nxt, done_nxt, error_nxt;
   logic [ROM_AW:0]   write_count_nxt;
   logic [DCW-1:0]    delay_cnt, delay_cnt_nxt;
   logic [TCW-1:0]    accept_cnt, accept_cnt_nxt;
   logic              start_req;

`ifdef CFG_AUTOSTART_EN
   localparam int PU_CYCLES = ms_to_cycles(POWERUP_MS, CLK_FREQ);
   localparam int PCW = (PU_CYCLES > 1) ? $clog2(PU_CYCLES) : 1;

   logic [PCW-1:0] pu_cnt;
   logic           pu_done;
   logic           pu_fire;

   // Manual starts are only honoured once the power-up wait has expired.
   assign pu_fire   = !pu_done && (pu_cnt == PCW'(PU_CYCLES - 1));
   assign start_req = pu_fire || (config_start && pu_done);

   // Power-up wait counter; fires exactly once per reset release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pu_cnt  <= '0;
         pu_done <= 1'b0;
      end else if (!pu_done) begin
         if (pu_fire) pu_done <= 1'b1;
         else         pu_cnt  <= pu_cnt + 1'b1;
      end
   end
`else
   logic [31:0] unused_powerup_ms;

   assign unused_powerup_ms = 32'(POWERUP_MS);
   assign start_req         = config_start;
`endif

   // Next-state and next-output logic for the table walk.
   always_comb begin
      state_nxt        = state;
      rom_addr_nxt     = rom_addr;
      sccb_start_nxt   = sccb_start;
      sccb_address_nxt = sccb_address;
      sccb_data_nxt    = sccb_data;
      busy_nxt         = busy;
      done_nxt         = done;
      error_nxt        = error;
      write_count_nxt  = write_count;
      delay_cnt_nxt    = delay_cnt;
      accept_cnt_nxt   = accept_cnt;

      case (state)
         ST_IDLE: begin
            if (start_req) begin
               done_nxt        = 1'b0;
               error_nxt       = 1'b0;
               write_count_nxt = '0;
               rom_addr_nxt    = '0;
               busy_nxt        = 1'b1;
               state_nxt       = ST_FETCH;
            end
         end
         ST_FETCH: state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (rom_data == CFG_END) begin
               state_nxt = ST_FINISH;
            end else if (rom_data == CFG_DELAY) begin
               delay_cnt_nxt = DCW'(DELAY_CYCLES - 1);
               state_nxt     = ST_DELAY;
            end else begin
               sccb_address_nxt = rom_data[15:8];
               sccb_data_nxt    = rom_data[7:0];
               state_nxt        = ST_WAIT_IDLE;
            end
         end
         // A master still busy from before a reset is waited out here too.
         ST_WAIT_IDLE: begin
            if (sccb_ready) begin
               sccb_start_nxt = 1'b1;
               accept_cnt_nxt = '0;
               state_nxt      = ST_WAIT_ACCEPT;
            end
         end
         ST_WAIT_ACCEPT: begin
            if (!sccb_ready) begin
               sccb_start_nxt = 1'b0;
               if (write_count != WC_MAX) write_count_nxt = write_count + 1'b1;
               state_nxt = ST_WAIT_DONE;
            end else if (accept_cnt == TCW'(ACCEPT_TIMEOUT - 1)) begin
               sccb_start_nxt = 1'b0;
               error_nxt      = 1'b1;
               state_nxt      = ST_FINISH;
            end else begin
               accept_cnt_nxt = accept_cnt + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (sccb_ready) state_nxt = ST_ADVANCE;
         end
         ST_DELAY: begin
            if (delay_cnt == '0) state_nxt = ST_ADVANCE;
            else                 delay_cnt_nxt = delay_cnt - 1'b1;
         end
         // The last table slot ends the run rather than wrapping to entry 0.
         ST_ADVANCE: begin
            if (&rom_addr) begin
               state_nxt = ST_FINISH;
            end else begin
               rom_addr_nxt = rom_addr + 1'b1;
               state_nxt    = ST_FETCH;
            end
         end
         ST_FINISH: begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rom_addr     <= '0;
         sccb_start   <= 1'b0;
         sccb_address <= '0;
         sccb_data    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         write_count  <= '0;
         delay_cnt    <= '0;
         accept_cnt   <= '0;
      end else begin
         state        <= state_nxt;
         rom_addr     <= rom_addr_nxt;
         sccb_start   <= sccb_start_nxt;
         sccb_address <= sccb_address_nxt;
         sccb_data    <= sccb_data_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         error        <= error_nxt;
         write_count  <= write_count_nxt;
         delay_cnt    <= delay_cnt_nxt;
         accept_cnt   <= accept_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// tb_camera_config_sequencer: table-driven runs against a ROM model and an SCCB master model with a scoreboard.
// Latency: n/a.
// Backpressure: the SCCB model holds sccb_ready low for a fixed time per accepted transaction.
`timescale 1ns/1ps
module tb_camera_config_sequencer;
   import camera_cfg_pkg::*;

   localparam int CLK_FREQ       = 100000;
   localparam int ROM_AW         = 2;
   localparam int DELAY_MS       = 10;
   localparam int ACCEPT_TIMEOUT = 64;
   localparam int POWERUP_MS     = 1;
   localparam int DELAY_CYC      = 1000;   // 10 ms at 100 kHz
   localparam int READY_LOW      = 20;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              config_start = 1'b0;
   logic [ROM_AW-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic              sccb_ready;
   logic              sccb_start;
   logic [7:0]        sccb_address;
   logic [7:0]        sccb_data;
   logic              busy;
   logic              done;
   logic              error;
   logic [ROM_AW:0]   write_count;

   logic [7:0]        rchk_addr = 8'd0;
   logic [15:0]       rchk_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   camera_config_sequencer #(
      .CLK_FREQ(CLK_FREQ), .ROM_AW(ROM_AW), .DELAY_MS(DELAY_MS),
      .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT), .POWERUP_MS(POWERUP_MS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .config_start(config_start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_ready(sccb_ready), .sccb_start(sccb_start),
      .sccb_address(sccb_address), .sccb_data(sccb_data),
      .busy(busy), .done(done), .error(error), .write_count(write_count)
   );

   camera_config_rom #(.ROM_AW(8)) u_rom (.clk(clk), .addr(rchk_addr), .data(rchk_data));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- ROM model: data one cycle after address ----------------
   logic [15:0]       rom_tbl [4];
   logic [ROM_AW-1:0] rom_a;
   initial begin
      rom_data = 16'h0;
      forever begin
         @(negedge clk);
         rom_a = rom_addr;
         @(posedge clk);
         #1 rom_data = rom_tbl[rom_a];
      end
   end

   // ---------------- SCCB master model + scoreboard ----------------
   logic [15:0] exp_q [$];
   bit model_ignore = 1'b0;
   bit model_hold = 1'b0;
   int n_txn = 0;
   int ready_rise_cyc = 0;
   int last_gap = 0;
   initial begin
      sccb_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (sccb_start && sccb_ready && !model_ignore) begin
            logic [15:0] e;
            last_gap = cyc - ready_rise_cyc;
            n_txn++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra: unexpected write %02h/%02h", sccb_address, sccb_data);
            end else begin
               e = exp_q.pop_front();
               chk("sb_write", {16'h0, sccb_address, sccb_data}, {16'h0, e});
            end
            sccb_ready = 1'b0;
            repeat (READY_LOW) @(negedge clk);
            while (model_hold) @(negedge clk);
            sccb_ready = 1'b1;
            ready_rise_cyc = cyc;
         end
      end
   end

   // ---------------- Protocol monitor ----------------
   int bad_start = 0;
   int start_run = 0;
   int start_max = 0;
   int start_samples = 0;
   bit addr_back = 1'b0;
   bit prev_busy = 1'b0;
   logic [ROM_AW-1:0] prev_addr = '0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sccb_start && !sccb_ready) bad_start++;
         if (sccb_start) begin
            start_run++;
            start_samples++;
            if (start_run > start_max) start_max = start_run;
         end else begin
            start_run = 0;
         end
         if (busy && prev_busy && (rom_addr < prev_addr)) addr_back = 1'b1;
         prev_busy = busy;
         prev_addr = rom_addr;
      end
   end

   // ---------------- Vector table ----------------
   typedef struct {
      logic [3:0][15:0] t;
      bit ignore;
      bit chk_gap;
      int exp_wc;
      bit exp_err;
      int exp_smax;
      int exp_last;
   } vec_t;
   vec_t vecs [6];

   task automatic set_vec(input int i, input logic [15:0] t0, input logic [15:0] t1,
                          input logic [15:0] t2, input logic [15:0] t3, input bit ign,
                          input bit gap, input int wc, input bit err, input int smax, input int last);
      vecs[i].t[0] = t0; vecs[i].t[1] = t1; vecs[i].t[2] = t2; vecs[i].t[3] = t3;
      vecs[i].ignore = ign; vecs[i].chk_gap = gap; vecs[i].exp_wc = wc;
      vecs[i].exp_err = err; vecs[i].exp_smax = smax; vecs[i].exp_last = last;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      config_start = 1'b1;
      @(negedge clk);
      config_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (!(done && !busy) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_finished"}, done && !busy, 1);
   endtask

   task automatic wait_txn(input int target, input int budget, input string tag);
      int n = 0;
      while (n_txn < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_txn_seen"}, (n_txn >= target), 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_sccb_start"}, sccb_start, 0);
      chk({tag, "_sccb_address"}, sccb_address, 0);
      chk({tag, "_sccb_data"}, sccb_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_write_count"}, write_count, 0);
   endtask

   task automatic load_pair_table();
      rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h1204; rom_tbl[2] = CFG_END; rom_tbl[3] = CFG_END;
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1204);
   endtask

   task automatic run_vec(input int i);
      string tag;
      tag = $sformatf("vec%0d", i);
      for (int k = 0; k < 4; k++) rom_tbl[k] = vecs[i].t[k];
      model_ignore = vecs[i].ignore;
      if (!vecs[i].ignore) begin
         for (int k = 0; k < 4; k++) begin
            if (vecs[i].t[k] == CFG_END) break;
            if (vecs[i].t[k] != CFG_DELAY) exp_q.push_back(vecs[i].t[k]);
         end
      end
      @(negedge clk);
      start_max = 0;
      pulse_start();
      wait_done(3000, tag);
      chk({tag, "_write_count"}, write_count, vecs[i].exp_wc);
      chk({tag, "_error"}, error, vecs[i].exp_err);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_last_rom_addr"}, rom_addr, vecs[i].exp_last);
      chk({tag, "_start_high_cycles"}, start_max, vecs[i].exp_smax);
      chk({tag, "_pending_writes"}, exp_q.size(), 0);
      if (vecs[i].chk_gap) begin
         // Delay length plus the state walk around it (advance, fetch, decode on both sides).
         checks++;
         if (last_gap < DELAY_CYC + 3 || last_gap > DELAY_CYC + 9) begin
            failures++;
            $display("FAIL %s_delay_gap: got %0d cycles expected %0d..%0d", tag, last_gap,
                     DELAY_CYC + 3, DELAY_CYC + 9);
         end
      end
      exp_q.delete();
      model_ignore = 1'b0;
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      int n0;
      int s0;
      //       t0        t1         t2        t3       ign gap wc err smax last
      set_vec(0, 16'h1280, 16'h1204,  CFG_END,  CFG_END, 0,  0,  2, 0,  1,   2);
      set_vec(1, 16'h1180, CFG_DELAY, 16'h1204, CFG_END, 0,  1,  2, 0,  1,   3);
      set_vec(2, 16'h1001, 16'h1002,  16'h1003, 16'h1004, 0, 0,  4, 0,  1,   3);
      set_vec(3, 16'h1280, CFG_END,   CFG_END,  CFG_END, 1,  0,  0, 1,  64,  0);
      set_vec(4, CFG_END,  16'h1280,  CFG_END,  CFG_END, 0,  0,  0, 0,  0,   0);
      set_vec(5, CFG_DELAY, CFG_END,  CFG_END,  CFG_END, 0,  0,  0, 0,  0,   1);
      for (int k = 0; k < 4; k++) rom_tbl[k] = CFG_END;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");

      // Real table spot checks while the sequencer is held in reset.
      @(negedge clk) rchk_addr = 8'd0;
      @(posedge clk) #1 chk("rom_entry0", rchk_data, 16'h1280);
      @(negedge clk) rchk_addr = 8'd1;
      @(posedge clk) #1 chk("rom_entry1", rchk_data, CFG_DELAY);
      @(negedge clk) rchk_addr = 8'd200;
      @(posedge clk) #1 chk("rom_entry200", rchk_data, CFG_END);

`ifdef CFG_AUTOSTART_EN
      load_pair_table();
      @(negedge clk) rst_n = 1'b1;
      n0 = 0;
      while (!busy && n0 < 400) begin
         @(posedge clk);
         #1;
         n0++;
      end
      checks++;
      if (n0 < 97 || n0 > 103) begin
         failures++;
         $display("FAIL autostart_delay: got %0d cycles expected 97..103", n0);
      end
      wait_done(500, "autostart");
      chk("autostart_write_count", write_count, 2);
      chk("autostart_pending", exp_q.size(), 0);
      exp_q.delete();
`else
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_autostart_busy", busy, 0);
`endif

      for (int i = 0; i < 6; i++) run_vec(i);

      // config_start while busy must not restart the walk.
      load_pair_table();
      n0 = n_txn;
      pulse_start();
      wait_txn(n0 + 1, 200, "busy_ign");
      pulse_start();
      wait_done(500, "busy_ign");
      chk("busy_ign_write_count", write_count, 2);
      chk("busy_ign_addr_monotonic", addr_back, 0);
      chk("busy_ign_pending", exp_q.size(), 0);
      exp_q.delete();

`ifndef CFG_AUTOSTART_EN
      // Reset while the SCCB master is mid-transaction, then restart.
      load_pair_table();
      n0 = n_txn;
      pulse_start();
      wait_txn(n0 + 1, 200, "mid_rst");
      model_hold = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset("mid_rst");
      @(negedge clk) rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(16'h1280);
      exp_q.push_back(16'h1204);
      s0 = start_samples;
      pulse_start();
      repeat (40) @(negedge clk);
      chk("mid_rst_no_start_while_held", start_samples - s0, 0);
      chk("mid_rst_busy_while_held", busy, 1);
      model_hold = 1'b0;
      wait_done(500, "mid_rst");
      chk("mid_rst_write_count", write_count, 2);
      chk("mid_rst_pending", exp_q.size(), 0);
      exp_q.delete();
`endif

      chk("start_while_master_busy", bad_start, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
